// File: rtl/interrupt_controller.sv
// Edge-triggered, masked, fixed-priority interrupt controller feeding a single INT line with ack/done handshake.
// Define INTC_SYNC_EN to insert a 2-flop synchronizer on irq_req ahead of the edge detector.
module interrupt_controller #(
  parameter int          NUM_SRC    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               INT,
  output logic [31:0]        int_vec,
  output logic [2:0]         int_id,
  output logic [NUM_SRC-1:0] int_pending,
  output logic               int_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] irq_s, req_q, rise;
  logic [NUM_SRC-1:0] mask_q, mask_d, pend_q, pend_d, elig;
  logic [2:0]         win, id_q, id_d;
  logic [31:0]        vec_q, vec_d;
  logic               int_q, int_d, busy_q, busy_d;

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_req;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_req;
`endif

  assign rise   = irq_s & ~req_q;
  // A mask write is already honoured by the selection on its own edge.
  assign mask_d = mask_we ? mask_wdata : mask_q;
  assign elig   = pend_q & mask_d;

  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (elig[i]) win = 3'(i);
  end

  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    busy_d  = busy_q;
    id_d    = id_q;
    vec_d   = vec_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: if (|elig) begin
        state_d = S_ASSERT;
        int_d   = 1'b1;
        id_d    = win;
        vec_d   = VEC_BASE + 32'(win) * VEC_STRIDE;
      end
      S_ASSERT: if (int_ack) begin
        state_d = S_SERVICE;
        int_d   = 1'b0;
        busy_d  = 1'b1;
        for (int i = 0; i < NUM_SRC; i++)
          if (3'(i) == id_q) pend_d[i] = 1'b0;
      end
      S_SERVICE: if (int_done) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // New edges win over the acknowledge clear on the same bit.
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      mask_q  <= '1;
      pend_q  <= '0;
      id_q    <= '0;
      vec_q   <= '0;
      int_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= irq_s;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
      int_q   <= int_d;
      busy_q  <= busy_d;
    end
  end

  assign INT         = int_q;
  assign int_vec     = vec_q;
  assign int_id      = id_q;
  assign int_pending = pend_q;
  assign int_busy    = busy_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller (default build): directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model of the controller.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq_req = '0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wdata = '0;
  logic        int_ack = 1'b0;
  logic        int_done = 1'b0;
  logic        INT;
  logic [31:0] int_vec;
  logic [2:0]  int_id;
  logic [3:0]  int_pending;
  logic        int_busy;

  int checks = 0;
  int passes = 0;

  // Behavioural model: what has been requested, what is masked, and where the handshake stands.
  bit [3:0]  m_pend, m_mask, m_prev;
  bit        waiting_ack, in_handler;
  int        m_id;
  bit [31:0] m_vec;

  interrupt_controller dut (
    .clk(clk), .rst(rst), .irq_req(irq_req), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .int_ack(int_ack), .int_done(int_done), .INT(INT), .int_vec(int_vec), .int_id(int_id),
    .int_pending(int_pending), .int_busy(int_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '1; m_prev = '0;
    waiting_ack = 0; in_handler = 0; m_id = 0; m_vec = '0;
  endtask

  task automatic model_edge(input bit [3:0] req, input bit we, input bit [3:0] wd,
                            input bit ack, input bit done);
    bit [3:0] newreq, ready;
    newreq = req & ~m_prev;
    m_prev = req;
    if (we) m_mask = wd;
    ready = m_pend & m_mask;
    if (waiting_ack) begin
      if (ack) begin
        m_pend[m_id] = 1'b0;
        waiting_ack  = 0;
        in_handler   = 1;
      end
    end else if (in_handler) begin
      if (done) in_handler = 0;
    end else if (ready != 0) begin
      for (int i = 3; i >= 0; i--) if (ready[i]) m_id = i;
      m_vec = 32'h0000_0100 + 32'(m_id) * 32'h0000_0010;
      waiting_ack = 1;
    end
    m_pend = m_pend | newreq;
  endtask

  task automatic compare_all();
    check("INT", {31'b0, INT}, {31'b0, waiting_ack});
    check("int_busy", {31'b0, int_busy}, {31'b0, in_handler});
    check("int_pending", {28'b0, int_pending}, {28'b0, m_pend});
    check("int_id", {29'b0, int_id}, 32'(m_id));
    check("int_vec", int_vec, m_vec);
  endtask

  // Called at a negedge: drive inputs, let one posedge happen, advance the model, compare.
  task automatic step(input logic [3:0] r, input logic we, input logic [3:0] wd,
                      input logic a, input logic d);
    irq_req = r; mask_we = we; mask_wdata = wd; int_ack = a; int_done = d;
    @(posedge clk);
    model_edge(r, we, wd, a, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic [3:0] r);
    step(r, 1'b0, 4'b0, 1'b0, 1'b0);
  endtask

  task automatic ack(input logic [3:0] r);
    step(r, 1'b0, 4'b0, 1'b1, 1'b0);
  endtask

  task automatic done(input logic [3:0] r);
    step(r, 1'b0, 4'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [3:0] r;
    model_reset();
    // 1: reset with lines held high; first posedge after release sees a rise.
    rst = 1'b0; irq_req = 4'b0011;
    repeat (2) @(negedge clk);
    compare_all();
    check("reset INT", {31'b0, INT}, 32'd0);
    check("reset mask", {28'b0, dut.mask_q}, 32'hF);
    rst = 1'b1;
    idle(4'b0011);
    check("t1 pending", {28'b0, int_pending}, 32'h3);
    idle(4'b0011);
    check("t1 INT", {31'b0, INT}, 32'd1);
    check("t1 id", {29'b0, int_id}, 32'd0);
    ack(4'b0011);
    check("t1 pend after ack", {28'b0, int_pending}, 32'h2);
    done(4'b0011);
    idle(4'b0011);
    check("t1 second id", {29'b0, int_id}, 32'd1);
    ack(4'b0011);
    done(4'b0011);
    idle(4'b0011);
    check("t1 held no retrigger", {28'b0, int_pending}, 32'h0);
    check("t1 held INT", {31'b0, INT}, 32'd0);
    idle(4'b0000);

    // 2: single pulse on source 2
    idle(4'b0100);
    check("t2 INT before", {31'b0, INT}, 32'd0);
    idle(4'b0000);
    check("t2 INT", {31'b0, INT}, 32'd1);
    check("t2 vec", int_vec, 32'h0000_0120);
    ack(4'b0000);
    check("t2 busy", {31'b0, int_busy}, 32'd1);
    check("t2 pend2", {31'b0, int_pending[2]}, 32'd0);
    done(4'b0000);
    check("t2 busy off", {31'b0, int_busy}, 32'd0);

    // 3: simultaneous sources 3 and 1
    idle(4'b1010);
    idle(4'b0000);
    check("t3 id", {29'b0, int_id}, 32'd1);
    check("t3 vec", int_vec, 32'h0000_0110);
    ack(4'b0000);
    done(4'b0000);
    idle(4'b0000);
    check("t3 vec src3", int_vec, 32'h0000_0130);
    ack(4'b0000);
    done(4'b0000);

    // 4: masked source stays pending and fires on unmask
    step(4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0);
    idle(4'b0001);
    idle(4'b0000);
    check("t4 masked INT", {31'b0, INT}, 32'd0);
    check("t4 pend0", {31'b0, int_pending[0]}, 32'd1);
    step(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0);
    check("t4 unmask INT", {31'b0, INT}, 32'd1);
    check("t4 unmask id", {29'b0, int_id}, 32'd0);
    ack(4'b0000);
    done(4'b0000);

    // 5: new edge coincides with ack of the same source; stray handshakes in IDLE
    idle(4'b0100);
    idle(4'b0000);
    ack(4'b0100);
    check("t5 set wins", {31'b0, int_pending[2]}, 32'd1);
    done(4'b0000);
    idle(4'b0000);
    check("t5 re-serve", {29'b0, int_id}, 32'd2);
    ack(4'b0000);
    done(4'b0000);
    step(4'b0000, 1'b0, 4'b0, 1'b1, 1'b1);
    check("t5 stray INT", {31'b0, INT}, 32'd0);
    check("t5 stray busy", {31'b0, int_busy}, 32'd0);

    // 6: asynchronous reset mid-service
    idle(4'b1000);
    idle(4'b0000);
    ack(4'b1001);
    #2 rst = 1'b0;
    #1 model_reset();
    check("t6 async INT", {31'b0, INT}, 32'd0);
    check("t6 async busy", {31'b0, int_busy}, 32'd0);
    check("t6 async pend", {28'b0, int_pending}, 32'h0);
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    irq_req = 4'b0000;
    idle(4'b0000);

    // Randomized traffic with one mid-run reset
    r = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) r = r ^ 4'($urandom);
      if (c == 300) begin
        rst = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;
      end
      step(r, $urandom_range(0, 7) == 0, 4'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
